// File: rtl/sha256_pkg.sv
// Shared constants, block type and state encoding for the SHA-256 message padder.
package sha256_pkg;
    localparam int         WORD_W       = 32;
    localparam int         BLOCK_WORDS  = 16;
    localparam int         BLOCK_W      = WORD_W * BLOCK_WORDS;
    localparam logic [7:0] PAD_MARKER   = 8'h80;
    localparam int         LEN_BYTE_OFS = 56;

    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        PAD2 = 2'd2
    } pad_state_e;
endpackage

// File: rtl/sha256_len_insert.sv
// Places a 64-bit big-endian bit length into words 14/15 in software lane order
// (byte 4i of the block sits in bits [7:0] of word i).
module sha256_len_insert
    import sha256_pkg::*;
(
    input  logic [63:0]       len_i,
    output logic [WORD_W-1:0] word14_o,
    output logic [WORD_W-1:0] word15_o
);
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word14_o[8*gi +: 8] = len_i[63-8*gi -: 8];
            assign word15_o[8*gi +: 8] = len_i[31-8*gi -: 8];
        end
    endgenerate
endmodule

// File: rtl/sha256_msg_padder.sv
// Streams 32-bit message words into FIPS 180-4 padded 512-bit blocks.
// Optional macro SHA256_PAD_BYPASS_EN adds a `bypass` input that disables padding.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [WORD_W-1:0]  s_data,
    input  logic [2:0]         s_bytes,
    input  logic               s_last,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [BLOCK_W-1:0] m_block,
    output logic               m_final,
    output logic               m_valid,
    input  logic               m_ready
`ifdef SHA256_PAD_BYPASS_EN
    ,
    input  logic               bypass
`endif
);
    pad_state_e        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    block_t            block_q, block_d;
    logic              final_q, final_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              pend_q, pend_d;
    logic              pend_mark_q, pend_mark_d;

    logic [WORD_W-1:0] beat_word;
    logic [6:0]        beat_end;
    logic [LEN_W-1:0]  len_sum;
    logic [LEN_W-1:0]  ins_len;
    logic [WORD_W-1:0] len_w14, len_w15;
    logic              accept;
    logic              byp_eff;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign beat_word[8*gi +: 8] = (3'(gi) < s_bytes) ? s_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign accept   = s_valid & ready_q;
    assign beat_end = {1'b0, idx_q, 2'b00} + {4'b0000, s_bytes};
    assign len_sum  = len_q + LEN_W'({s_bytes, 3'b000});
    // PAD2 reuses the already-updated length; FILL needs the length including this beat.
    assign ins_len  = (state_q == PAD2) ? len_q : len_sum;

    sha256_len_insert u_len_insert (
        .len_i    (64'(ins_len)),
        .word14_o (len_w14),
        .word15_o (len_w15)
    );

`ifdef SHA256_PAD_BYPASS_EN
    logic byp_q;
    logic first_q;

    assign byp_eff = first_q ? bypass : byp_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            byp_q   <= 1'b0;
            first_q <= 1'b1;
        end else if (accept) begin
            byp_q   <= byp_eff;
            first_q <= 1'b0;
        end else if (state_q == EMIT && m_ready && final_q) begin
            first_q <= 1'b1;
        end
    end
`else
    assign byp_eff = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        block_d     = block_q;
        final_d     = final_q;
        pend_d      = pend_q;
        pend_mark_d = pend_mark_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    block_d[idx_q] = beat_word;
                    idx_d          = idx_q + 4'd1;
                    len_d          = len_sum;
                    if (s_last && !byp_eff) begin
                        state_d = EMIT;
                        if (s_bytes == 3'd4) begin
                            if (idx_q != 4'd15) begin
                                block_d[idx_q + 4'd1] = 32'(PAD_MARKER);
                            end
                        end else begin
                            block_d[idx_q] = beat_word | (32'(PAD_MARKER) << {s_bytes[1:0], 3'b000});
                        end
                        if (beat_end < 7'(LEN_BYTE_OFS)) begin
                            block_d[14] = len_w14;
                            block_d[15] = len_w15;
                            final_d     = 1'b1;
                        end else begin
                            final_d     = 1'b0;
                            pend_d      = 1'b1;
                            pend_mark_d = (beat_end == 7'd64);
                        end
                    end else if (s_last) begin
                        state_d = EMIT;
                        final_d = 1'b1;
                    end else if (idx_q == 4'd15) begin
                        state_d = EMIT;
                        final_d = 1'b0;
                    end
                end
            end
            PAD2: begin
                block_d = '0;
                if (pend_mark_q) begin
                    block_d[0] = 32'(PAD_MARKER);
                end
                block_d[14] = len_w14;
                block_d[15] = len_w15;
                final_d     = 1'b1;
                pend_d      = 1'b0;
                pend_mark_d = 1'b0;
                state_d     = EMIT;
            end
            EMIT: begin
                if (m_ready) begin
                    block_d = '0;
                    final_d = 1'b0;
                    if (pend_q) begin
                        state_d = PAD2;
                    end else begin
                        state_d = FILL;
                        idx_d   = 4'd0;
                        if (final_q) begin
                            len_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        valid_d = (state_d == EMIT);
        ready_d = (state_d == FILL);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= FILL;
            idx_q       <= 4'd0;
            len_q       <= '0;
            block_q     <= '0;
            final_q     <= 1'b0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            pend_q      <= 1'b0;
            pend_mark_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            block_q     <= block_d;
            final_q     <= final_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            pend_q      <= pend_d;
            pend_mark_q <= pend_mark_d;
        end
    end

    assign s_ready = ready_q;
    assign m_valid = valid_q;
    assign m_final = final_q;
    assign m_block = block_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: directed vector table, multi-cycle
// corner sequences and random messages against a byte-queue padding model.
module tb_sha256_msg_padder;
    logic         clk = 1'b0;
    logic         aresetn;
    logic [31:0]  s_data;
    logic [2:0]   s_bytes;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] m_block;
    logic         m_final;
    logic         m_valid;
    logic         m_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [511:0] blk;
        logic         fin;
    } blk_t;

    typedef struct {
        int          msg;
        int          blk;
        int          word;
        logic [31:0] w;
        logic        fin;
    } spot_t;

    logic [7:0] msg_q[$];
    blk_t       rx_q[$];
    blk_t       exp_q[$];
    blk_t       rx_save[$];
    spot_t      spots[14];
    bit         rand_rdy = 1'b0;
    bit         rand_gap = 1'b0;

    sha256_msg_padder dut (
        .aclk    (clk),
        .aresetn (aresetn),
        .s_data  (s_data),
        .s_bytes (s_bytes),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_block (m_block),
        .m_final (m_final),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef SHA256_PAD_BYPASS_EN
        ,
        .bypass  (1'b0)
`endif
    );

    always #5 clk = ~clk;

    initial begin : rdy_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // A block is taken at the posedge following a negedge where valid & ready hold.
    always @(negedge clk) begin
        if (aresetn === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1)
            rx_q.push_back({m_block, m_final});
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void set_msg(input int id);
        logic [31:0] w;
        msg_q.delete();
        case (id)
            0: begin
                msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
            end
            2: begin
                for (int i = 0; i < 16; i++) begin
                    if (i == 0) w = 32'h64343962;
                    else if (i == 15) w = 32'h39656463;
                    else w = 32'h30303030 + 32'h01010101 * i;
                    for (int k = 0; k < 4; k++) msg_q.push_back(w[8*k +: 8]);
                end
            end
            3: begin
                for (int k = 0; k < 56; k++) msg_q.push_back(8'(8'h41 + k % 26));
            end
            default: ;
        endcase
    endfunction

    // Reference: append marker, zero-fill to 56 mod 64, append 64-bit big-endian length.
    function automatic void build_expected();
        logic [7:0] p[$];
        logic [63:0] bl;
        int nb;
        blk_t e;
        p = msg_q;
        bl = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nb = p.size() / 64;
        exp_q.delete();
        for (int j = 0; j < nb; j++) begin
            e.blk = '0;
            for (int w = 0; w < 16; w++)
                for (int k = 0; k < 4; k++)
                    e.blk[32*w + 8*k +: 8] = p[64*j + 4*w + k];
            e.fin = (j == nb - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic drive_beat(input logic [31:0] d, input logic [2:0] nb, input bit last);
        int guard;
        if (rand_gap && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_data  = d;
        s_bytes = nb;
        s_last  = last;
        s_valid = 1'b1;
        guard   = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (s_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept_timeout: got s_ready=%b expected 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_msg(input bit extra_empty);
        int L;
        int nb;
        logic [31:0] d;
        bit extra;
        L = msg_q.size();
        extra = extra_empty && (L % 4 == 0);
        for (int i = 0; i < L; i += 4) begin
            nb = (L - i >= 4) ? 4 : L - i;
            d = $urandom();
            for (int k = 0; k < nb; k++) d[8*k +: 8] = msg_q[i + k];
            drive_beat(d, 3'(nb), (i + 4 >= L) && !extra);
        end
        if (L == 0 || extra) drive_beat($urandom(), 3'd0, 1'b1);
    endtask

    task automatic wait_blocks(input int n, input string name);
        int guard = 0;
        while (rx_q.size() < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_count"}, 512'(rx_q.size()), 512'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic compare_blocks(input string name);
        int n;
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_blk%0d", name, i), rx_q[i].blk, exp_q[i].blk);
            chk($sformatf("%s_fin%0d", name, i), 512'(rx_q[i].fin), 512'(exp_q[i].fin));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic run_msg(input string name, input bit extra);
        build_expected();
        send_msg(extra);
        wait_blocks(exp_q.size(), name);
        rx_save = rx_q;
        compare_blocks(name);
    endtask

    task automatic wait_valid(input string name);
        int guard = 0;
        while (m_valid !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_valid_seen"}, 512'(m_valid), 512'(1));
    endtask

    task automatic directed();
        blk_t t;
        for (int id = 0; id < 4; id++) begin
            set_msg(id);
            run_msg($sformatf("dir%0d", id), 1'b0);
            foreach (spots[s]) begin
                if (spots[s].msg == id) begin
                    if (spots[s].blk < rx_save.size()) begin
                        t = rx_save[spots[s].blk];
                        chk($sformatf("spot_m%0d_b%0d_w%0d", id, spots[s].blk, spots[s].word),
                            512'(t.blk[32*spots[s].word +: 32]), 512'(spots[s].w));
                        chk($sformatf("spot_m%0d_b%0d_final", id, spots[s].blk),
                            512'(t.fin), 512'(spots[s].fin));
                    end else begin
                        chk($sformatf("spot_m%0d_b%0d_present", id, spots[s].blk),
                            512'(rx_save.size()), 512'(spots[s].blk + 1));
                    end
                end
            end
        end
    endtask

    task automatic backpressure();
        logic [511:0] snap;
        logic snapf;
        m_ready = 1'b0;
        set_msg(0);
        build_expected();
        send_msg(1'b0);
        wait_valid("bp");
        snap  = m_block;
        snapf = m_final;
        chk("bp_snap_block", snap, exp_q[0].blk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_valid%0d", c), 512'(m_valid), 512'(1));
            chk($sformatf("bp_hold_block%0d", c), m_block, snap);
            chk($sformatf("bp_hold_final%0d", c), 512'(m_final), 512'(snapf));
            chk($sformatf("bp_hold_sready%0d", c), 512'(s_ready), 512'(0));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_sready", 512'(s_ready), 512'(1));
        chk("bp_release_mvalid", 512'(m_valid), 512'(0));
        chk("bp_release_count", 512'(rx_q.size()), 512'(1));
        compare_blocks("bp");
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string name);
        aresetn = 1'b0;
        #1;
        chk({name, "_mvalid"}, 512'(m_valid), 512'(0));
        chk({name, "_sready"}, 512'(s_ready), 512'(1));
        chk({name, "_mfinal"}, 512'(m_final), 512'(0));
        chk({name, "_block"}, m_block, 512'(0));
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        m_ready = 1'b1;
        rx_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_tests();
        for (int b = 0; b < 5; b++) drive_beat($urandom(), 3'd4, 1'b0);
        reset_checks("rst_5beats");
        set_msg(0);
        run_msg("rst_5beats_abc", 1'b0);

        m_ready = 1'b0;
        set_msg(0);
        send_msg(1'b0);
        wait_valid("rst_emit");
        @(posedge clk);
        #1;
        reset_checks("rst_emit");
        set_msg(0);
        run_msg("rst_emit_abc", 1'b0);
    endtask

    task automatic random_msgs();
        int L;
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: L = $urandom_range(0, 8);
                1: L = $urandom_range(52, 68);
                2: L = $urandom_range(112, 132);
                default: L = $urandom_range(0, 200);
            endcase
            msg_q.delete();
            for (int k = 0; k < L; k++) msg_q.push_back(8'($urandom()));
            run_msg($sformatf("rnd%0d_len%0d", n, L), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
    endtask

    initial begin : main
        spots[0]  = '{0, 0, 0,  32'h80636261, 1'b1};
        spots[1]  = '{0, 0, 1,  32'h00000000, 1'b1};
        spots[2]  = '{0, 0, 14, 32'h00000000, 1'b1};
        spots[3]  = '{0, 0, 15, 32'h18000000, 1'b1};
        spots[4]  = '{1, 0, 0,  32'h00000080, 1'b1};
        spots[5]  = '{1, 0, 15, 32'h00000000, 1'b1};
        spots[6]  = '{2, 0, 0,  32'h64343962, 1'b0};
        spots[7]  = '{2, 0, 15, 32'h39656463, 1'b0};
        spots[8]  = '{2, 1, 0,  32'h00000080, 1'b1};
        spots[9]  = '{2, 1, 15, 32'h00020000, 1'b1};
        spots[10] = '{3, 0, 14, 32'h00000080, 1'b0};
        spots[11] = '{3, 0, 15, 32'h00000000, 1'b0};
        spots[12] = '{3, 1, 0,  32'h00000000, 1'b1};
        spots[13] = '{3, 1, 15, 32'hC0010000, 1'b1};

        aresetn = 1'b0;
        s_data  = '0;
        s_bytes = '0;
        s_last  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_sready", 512'(s_ready), 512'(1));
        chk("reset_mvalid", 512'(m_valid), 512'(0));
        chk("reset_mfinal", 512'(m_final), 512'(0));
        chk("reset_block", m_block, 512'(0));
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        directed();
        backpressure();
        reset_tests();
        random_msgs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream stage of the SHA-256 AXI-Full core.
- Accepts a raw message as a stream of 32-bit words, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length) and emits complete 512-bit blocks.
- The core consumes each block in the same word/lane layout software writes to the data window (word i = byte offsets 4i..4i+3, byte 4i in bits [7:0]).
- Removes the software padding step: for a 64-byte message, the hand-built second block `00000080 … 00020000` is produced here.

Parameters:
- LEN_W, 64, width of the internal bit-length counter; must be ≤64; upper bits of the length field are zero-extended.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous assert, active-low
- s_data  in  32  message word, byte k of the beat in [8k+7:8k]
- s_bytes  in  3  valid bytes in the beat, 0..4, low lanes first; must be 4 unless s_last
- s_last  in  1  final beat of message
- s_valid  in  1  beat valid
- s_ready  out  1  beat accepted when s_valid & s_ready
- m_block  out  512  block, word i at [32i+31:32i]
- m_final  out  1  block is the last of the message
- m_valid  out  1  block valid, held until taken
- m_ready  in  1  core ready; block transferred when m_valid & m_ready

Behaviour:
- Reset (asynchronous, aresetn low): state FILL, word index 0, length 0, block register 0, m_valid 0, m_final 0, s_ready 1. Reset mid-message discards the partial block.
- FILL:
  - s_ready=1. Each accepted beat writes its word at the word index, increments the index and adds 8*s_bytes to the length.
  - Byte lanes at or above s_bytes are forced to 0.
- Full-block boundary: when the 16th word is accepted without s_last, go to EMIT with m_final=0. m_valid rises the cycle after the accepting edge.
- Last beat, same edge. Let b = the message byte offset within the block after this beat (0..64).
  - b ≤ 55: write 0x80 at byte b, zero bytes b+1..55, write the length to bytes 56..63 (byte 63 = LSB, so word15 = {len[7:0],len[15:8],len[23:16],len[31:24]}). Go to EMIT with m_final=1.
  - 56 ≤ b ≤ 63: write 0x80 at byte b, zero the rest. Go to EMIT with m_final=0, then PAD2.
  - b = 64 (last beat completes the block): EMIT with m_final=0, then PAD2 with 0x80 at byte 0.
  - s_bytes=0 on last is legal: b unchanged, and the empty message yields word0=0x00000080, all other words 0.
- EMIT:
  - s_ready=0, m_valid=1; m_block and m_final are stable until the handshake.
  - On handshake: return to FILL with index 0 and block cleared; or go to PAD2 if a pad block is pending.
  - The length counter clears only after the final block's handshake.
- PAD2: build zero block plus marker (if pending) plus length, m_final=1, m_valid the next cycle, then EMIT.
- No beat is accepted while m_valid=1. There is no simultaneous accept and emit, so back-to-back blocks cost at least one bubble.
- Length arithmetic wraps modulo 2^LEN_W; no error flag.

Optional Feature:
- Macro: SHA256_PAD_BYPASS_EN.
- Defined: adds input port `bypass` (1 bit), sampled on the first beat of a message.
  - When bypass is high, no marker or length is inserted and every block is emitted only when 16 words are full.
  - s_last marks that block m_final=1.
  - A short last block is emitted zero-filled.
- Undefined: the port is absent and padding is always applied.

Decomposition:
- Shared package sha256_pkg:
  - block/word width constants
  - PAD_MARKER=8'h80
  - LEN_BYTE_OFS=56
  - state encoding FILL/EMIT/PAD2
- One natural sub-module, sha256_len_insert: a combinational function placing the 64-bit big-endian length into words 14–15 in lane order. It is shared with the core's self-test.
- Everything else lives in one module.

Test Plan:
- "abc" (one beat, s_data=0x00636261, s_bytes=3, s_last) -> one block: word0=0x80636261, words1–14=0, word15=0x18000000, m_final=1.
- Empty message (s_bytes=0, s_last) -> word0=0x00000080, all others 0, m_final=1.
- 64-byte message (16 full beats, 0x64343962…0x39656463) -> block1 equals the input words with m_final=0; block2 word0=0x00000080, word15=0x00020000, m_final=1. Feeding both blocks to the core yields digest 049da052…8f00249c.
- 56-byte message (14 beats) -> block1 word14=0x00000080, word15=0, m_final=0; block2 all zero except word15=0xC0010000, m_final=1.
- Backpressure: hold m_ready=0 for 10 cycles -> m_block/m_final stable, s_ready=0 throughout; release -> one handshake, then s_ready=1 next cycle.
- Reset asserted after 5 beats -> m_valid=0 and s_ready=1 immediately. A subsequent "abc" produces exactly the block from the first scenario.
